// File: rtl/byte_data_mem_pkg.sv
// Shared types and helpers for the byte-addressed big-endian data memory.
package data_mem_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    // Number of bytes touched by an access; reserved size reports 1 and is flagged elsewhere.
    function automatic logic [2:0] size_bytes(input mem_size_e sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    // Right-aligned raw load value extended to 32 bits.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input mem_size_e        sz,
                                                      input logic             uns);
        logic [DATA_W-1:0] v;
        case (sz)
            SZ_BYTE: v = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            SZ_HALF: v = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            SZ_WORD: v = raw;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/byte_data_mem.sv
// Byte-addressed big-endian data memory with valid/ready request, 1-cycle
// registered response, range/size error reporting and post-reset zero-fill.
module byte_data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = 6,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W - 2;

    logic [7:0]        mem [DEPTH];

    state_e            r_state;
    state_e            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    mem_size_e         w_size;
    logic [ADDR_W:0]   w_end;
    logic              w_err;
    logic              w_accept;
    logic [ADDR_W-1:0] w_a [4];
    logic [31:0]       w_raw;

    assign req_ready = (r_state == ST_IDLE);
    assign init_busy = (r_state == ST_INIT);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_size   = mem_size_e'(req_size);
    assign w_accept = req_valid & req_ready & ~rst;

    // Range check on last byte address, computed one bit wider so it cannot wrap.
    always_comb begin
        w_end = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(w_size)) - (ADDR_W+1)'(1);
        w_err = (w_end > (ADDR_W+1)'(DEPTH - 1)) | (w_size == SZ_RSVD);
    end

    // Byte addresses a..a+3 and the right-aligned big-endian raw load value.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_a[k] = req_addr + ADDR_W'(k);
        end
        case (w_size)
            SZ_BYTE: w_raw = {24'd0, mem[w_a[0]]};
            SZ_HALF: w_raw = {16'd0, mem[w_a[0]], mem[w_a[1]]};
            SZ_WORD: w_raw = {mem[w_a[0]], mem[w_a[1]], mem[w_a[2]], mem[w_a[3]]};
            default: w_raw = '0;
        endcase
    end

    // Next-state: INIT leaves once the last word has been zeroed.
    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_INIT && r_cnt == '1) begin
            w_next_state = ST_IDLE;
        end
    end

    // State register and zero-fill word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Storage: zero one aligned word per INIT cycle, otherwise big-endian stores.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                for (int k = 0; k < 4; k++) begin
                    mem[{r_cnt, 2'(k)}] <= 8'd0;
                end
            end else if (w_accept && req_we && !w_err) begin
                case (w_size)
                    SZ_WORD: begin
                        mem[w_a[0]] <= req_wdata[31:24];
                        mem[w_a[1]] <= req_wdata[23:16];
                        mem[w_a[2]] <= req_wdata[15:8];
                        mem[w_a[3]] <= req_wdata[7:0];
                    end
                    SZ_HALF: begin
                        mem[w_a[0]] <= req_wdata[15:8];
                        mem[w_a[1]] <= req_wdata[7:0];
                    end
                    SZ_BYTE: begin
                        mem[w_a[0]] <= req_wdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered one-cycle response; data only for error-free loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept & w_err;
            r_rsp_rdata <= (w_accept && !w_err && !req_we)
                           ? load_extend(w_raw, w_size, req_unsigned) : '0;
        end
    end

endmodule

// File: tb/tb_byte_data_mem.sv
// Directed scoreboard bench for byte_data_mem (ADDR_W=6, INIT_ON_RESET=1).
module tb_byte_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic drv_req = 1'b0;
    logic mon_acc;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

    byte_data_mem #(.ADDR_W(6), .INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Response monitor: rsp_valid must follow each driven request by one cycle.
    always @(posedge clk) begin
        exp_t e;
        mon_acc = drv_req;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(mon_acc));
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [5:0] addr, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee);
        exp_t e;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; drv_req = 1'b1;
        e.rdata = er; e.err = ee;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; drv_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at the first negedge after a reset edge.
    task automatic check_init();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk("init_busy", 32'(init_busy), 32'd1);
            chk("init_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        chk("init_done_busy", 32'(init_busy), 32'd0);
        chk("init_done_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; req_valid = 1'b0; drv_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = W;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_init();

        // 1: zero-filled after init
        do_req(1'b0, W, 1'b0, 6'd0, 32'd0, 32'h0000_0000, 1'b0);
        // 2: word store then mixed loads
        do_req(1'b1, W, 1'b0, 6'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        do_req(1'b0, W, 1'b0, 6'd4, 32'd0, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, B, 1'b0, 6'd4, 32'd0, 32'hFFFF_FFDE, 1'b0);
        do_req(1'b0, B, 1'b1, 6'd5, 32'd0, 32'h0000_00AD, 1'b0);
        do_req(1'b0, H, 1'b0, 6'd6, 32'd0, 32'hFFFF_BEEF, 1'b0);
        idle(1);
        // 3: byte and half stores leave other bytes alone
        do_req(1'b1, B, 1'b0, 6'd7, 32'h1234_567F, 32'd0, 1'b0);
        do_req(1'b0, W, 1'b0, 6'd4, 32'd0, 32'hDEAD_BE7F, 1'b0);
        do_req(1'b1, H, 1'b0, 6'd4, 32'h0000_CAFE, 32'd0, 1'b0);
        do_req(1'b0, W, 1'b0, 6'd4, 32'd0, 32'hCAFE_BE7F, 1'b0);
        do_req(1'b0, H, 1'b1, 6'd4, 32'd0, 32'h0000_CAFE, 1'b0);
        idle(2);
        // 4: boundaries and reserved size
        do_req(1'b1, W, 1'b0, 6'd60, 32'hA1B2_C3D4, 32'd0, 1'b0);
        do_req(1'b1, W, 1'b0, 6'd61, 32'h5555_5555, 32'd0, 1'b1);
        do_req(1'b0, W, 1'b0, 6'd60, 32'd0, 32'hA1B2_C3D4, 1'b0);
        do_req(1'b0, H, 1'b0, 6'd63, 32'd0, 32'd0, 1'b1);
        do_req(1'b0, B, 1'b0, 6'd63, 32'd0, 32'hFFFF_FFD4, 1'b0);
        do_req(1'b0, R, 1'b0, 6'd4, 32'd0, 32'd0, 1'b1);
        do_req(1'b1, R, 1'b0, 6'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        do_req(1'b0, W, 1'b0, 6'd0, 32'd0, 32'h0000_0000, 1'b0);
        idle(1);
        // 5: back-to-back store then load of same word
        do_req(1'b1, W, 1'b0, 6'd8, 32'h1122_3344, 32'd0, 1'b0);
        do_req(1'b0, W, 1'b0, 6'd8, 32'd0, 32'h1122_3344, 1'b0);
        idle(2);

        // 6a: reset right after an accepted load, with a request held during reset
        do_req(1'b1, W, 1'b0, 6'd0, 32'h9988_7766, 32'd0, 1'b0);
        do_req(1'b0, W, 1'b0, 6'd0, 32'd0, 32'h9988_7766, 1'b0);
        rst = 1'b1; drv_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
        check_init();
        // 6b: reset in the middle of INIT restarts the full sweep
        do_req(1'b1, W, 1'b0, 6'd60, 32'h0BAD_F00D, 32'd0, 1'b0);
        idle(1);
        pulse_reset();
        repeat (5) @(negedge clk);
        chk("mid_init_busy", 32'(init_busy), 32'd1);
        pulse_reset();
        check_init();
        do_req(1'b0, W, 1'b0, 6'd0, 32'd0, 32'h0000_0000, 1'b0);
        do_req(1'b0, W, 1'b0, 6'd4, 32'd0, 32'h0000_0000, 1'b0);
        do_req(1'b0, W, 1'b0, 6'd60, 32'd0, 32'h0000_0000, 1'b0);
        idle(3);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
